// File: rtl/shift_unit_arbiter_pkg.sv
// Shared shift-unit definitions: shift type codes, a width-generic bit reversal
// and the round-robin find-first helper used by shift_unit_arbiter.
package shift_unit_arbiter_pkg;

  localparam int unsigned MAX_W   = 64;  // widest operand bitrev supports
  localparam int unsigned MAX_REQ = 8;   // most requesters rr_pick supports

  localparam logic [1:0] SHT_LEFT  = 2'b00;
  localparam logic [1:0] SHT_LEFT1 = 2'b01;
  localparam logic [1:0] SHT_SRL   = 2'b10;
  localparam logic [1:0] SHT_SRA   = 2'b11;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Reverse the low w bits of x; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x,
                                              input int unsigned     w);
    logic [MAX_W-1:0] r;
    logic [5:0]       j;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      j = 6'(w - 1 - i);
      if (i < w) r[i] = x[j];
    end
    return r;
  endfunction

  // First asserted valid bit at or after ptr, searching circularly over n entries.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int unsigned        n);
    rr_pick_t   p;
    logic [3:0] idx;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 4'(ptr) + 4'(k);
      if (32'(idx) >= n) idx = idx - 4'(n);
      if ((k < n) && !p.found && valid[idx[2:0]]) begin
        p.found = 1'b1;
        p.idx   = idx[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/left_bshifter.sv
// Combinational left barrel shifter, zero fill; bits shifted past the top are lost.
//   data     : operand
//   shamt    : shift amount
//   result_c : data << shamt (combinational)
module left_bshifter #(
  parameter int unsigned IN_WIDTH = 32,
  parameter int unsigned SHAMT_W  = $clog2(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0] data,
  input  logic [SHAMT_W-1:0]  shamt,
  output logic [IN_WIDTH-1:0] result_c
);

  assign result_c = data << shamt;

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one left barrel shifter between NREQ requesters.
// Right shifts reverse bits around the shifter; the result lands in a single
// registered response slot tagged with the requester index.
//   clk, rst_n   : clock, async active-low reset
//   req_valid    : per-requester request valid
//   req_ready    : per-requester accept (combinational)
//   req_data     : operands, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_shamt    : shift amounts, packed the same way
//   req_type     : 00/01 left, 10 logical right, 11 arithmetic right
//   rsp_valid    : response slot full
//   rsp_ready    : consumer accepts the response
//   rsp_data     : shifted result
//   rsp_id       : index of the requester that produced rsp_data
module shift_unit_arbiter
  import shift_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH),
  parameter int unsigned ID_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NREQ*SHAMT_W-1:0]      req_shamt,
  input  logic [NREQ*2-1:0]            req_type,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [ID_W-1:0]              rsp_id
);

  logic [ID_W-1:0]       rr_ptr;
  rr_pick_t              pick;
  logic [ID_W-1:0]       win;
  logic                  can_accept;
  logic                  grant;

  logic [DATA_WIDTH-1:0] op_data;
  logic [SHAMT_W-1:0]    op_shamt;
  logic [1:0]            op_type;
  logic                  right;
  logic                  arith;
  logic                  flip;
  logic [DATA_WIDTH-1:0] op_x;
  logic [DATA_WIDTH-1:0] sh_in;
  logic [DATA_WIDTH-1:0] sh_out;
  logic [DATA_WIDTH-1:0] result;

  logic                  nxt_valid;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [ID_W-1:0]       nxt_id;
  logic [ID_W-1:0]       nxt_ptr;

  // Arbitration and grant
  always_comb begin
    pick       = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), NREQ);
    win        = ID_W'(pick.idx);
    can_accept = !rsp_valid || rsp_ready;
    grant      = pick.found && can_accept && rst_n;
    req_ready  = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  // Winner operand mux
  always_comb begin
    op_data  = '0;
    op_shamt = '0;
    op_type  = SHT_LEFT;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == win) begin
        op_data  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        op_shamt = req_shamt[k*SHAMT_W +: SHAMT_W];
        op_type  = req_type[k*2 +: 2];
      end
    end
  end

  // Shift path. A negative arithmetic shift is done as ~srl(~x), which yields
  // the same sign fill as OR-ing in the top-n mask without a second shifter.
  always_comb begin
    right = 1'b0;
    arith = 1'b0;
    unique case (op_type)
      SHT_LEFT, SHT_LEFT1: right = 1'b0;
      SHT_SRL:             right = 1'b1;
      SHT_SRA: begin
        right = 1'b1;
        arith = 1'b1;
      end
      default:             right = 1'b0;
    endcase
    flip   = arith && op_data[DATA_WIDTH-1];
    op_x   = op_data ^ {DATA_WIDTH{flip}};
    sh_in  = right ? DATA_WIDTH'(bitrev(MAX_W'(op_x), DATA_WIDTH)) : op_x;
    result = right ? (DATA_WIDTH'(bitrev(MAX_W'(sh_out), DATA_WIDTH)) ^ {DATA_WIDTH{flip}})
                   : sh_out;
  end

  left_bshifter #(
    .IN_WIDTH (DATA_WIDTH),
    .SHAMT_W  (SHAMT_W)
  ) u_bshifter (
    .data     (sh_in),
    .shamt    (op_shamt),
    .result_c (sh_out)
  );

  // Slot next state: a new accept wins over a drain in the same cycle
  always_comb begin
    nxt_valid = rsp_valid;
    nxt_data  = rsp_data;
    nxt_id    = rsp_id;
    nxt_ptr   = rr_ptr;
    if (grant) begin
      nxt_valid = 1'b1;
      nxt_data  = result;
      nxt_id    = win;
      if (32'(win) == NREQ - 1) nxt_ptr = '0;
      else                      nxt_ptr = win + ID_W'(1);
    end else if (rsp_valid && rsp_ready) begin
      nxt_valid = 1'b0;
    end
  end

  // Slot and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      rsp_valid <= nxt_valid;
      rsp_data  <= nxt_data;
      rsp_id    <= nxt_id;
      rr_ptr    <= nxt_ptr;
    end
  end

endmodule
